// File: rtl/panel_sequencer.sv
// Front-panel command sequencer: decodes debounced panel strobes in HALT and executes
// LOAD ADD / EXTD ADDR LOAD / DEP / EXAM / CLEAR / CONT against a req/ack memory port.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_IDLE   | waiting for a triggerd rising edge while CPU is halted
//  S_DECODE | command latched; register-only commands act here
//  S_MEM_RD | EXAM read in flight, waiting for mem_ack or timeout
//  S_MEM_WR | DEP write in flight, waiting for mem_ack or timeout
//  S_INC    | post-access cpma increment (12-bit wrap, ifr untouched)
//  S_DONE   | one cycle of settle before returning to IDLE
module panel_sequencer #(
    parameter logic [4:0] HALT_STATE  = 5'h00,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  state,
    input  logic        triggerd,
    input  logic        cleard,
    input  logic        extd_addrd,
    input  logic        addr_loadd,
    input  logic        depd,
    input  logic        examd,
    input  logic        contd,
    input  logic [11:0] sr,
    input  logic [11:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic [11:0] cpma,
    output logic [2:0]  ifr,
    output logic [2:0]  dfr,
    output logic [11:0] mb,
    output logic        cpu_clear,
    output logic        cpu_run,
    output logic        busy,
    output logic        mem_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_RD, S_MEM_WR, S_INC, S_DONE
    } fsm_t;

    typedef enum logic [2:0] {
        C_NONE, C_CLEAR, C_EXTD, C_LOAD, C_DEP, C_EXAM, C_CONT
    } cmd_t;

    // Down-counter loaded in DECODE; terminal count 0 marks the last allowed wait cycle.
    localparam logic [3:0] TMO_LOAD = 4'(ACK_TIMEOUT - 1);

    fsm_t        fsm_q, fsm_d;
    cmd_t        cmd_q, cmd_d;
    logic        trig_q, trig_d;
    logic [11:0] sr_q, sr_d;
    logic [11:0] cpma_q, cpma_d;
    logic [2:0]  ifr_q, ifr_d;
    logic [2:0]  dfr_q, dfr_d;
    logic [11:0] mb_q, mb_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        mem_err_q, mem_err_d;
    logic        accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q     <= S_IDLE;
            cmd_q     <= C_NONE;
            trig_q    <= 1'b0;
            sr_q      <= '0;
            cpma_q    <= '0;
            ifr_q     <= '0;
            dfr_q     <= '0;
            mb_q      <= '0;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cmd_q     <= cmd_d;
            trig_q    <= trig_d;
            sr_q      <= sr_d;
            cpma_q    <= cpma_d;
            ifr_q     <= ifr_d;
            dfr_q     <= dfr_d;
            mb_q      <= mb_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign accept = triggerd && !trig_q && (fsm_q == S_IDLE) && (state == HALT_STATE);

    always_comb begin
        fsm_d     = fsm_q;
        cmd_d     = cmd_q;
        trig_d    = triggerd;
        sr_d      = sr_q;
        cpma_d    = cpma_q;
        ifr_d     = ifr_q;
        dfr_d     = dfr_q;
        mb_d      = mb_q;
        tmo_d     = tmo_q;
        mem_err_d = mem_err_q;
        cpu_clear = 1'b0;
        cpu_run   = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    fsm_d     = S_DECODE;
                    sr_d      = sr;
                    mem_err_d = 1'b0;
                    if (cleard)          cmd_d = C_CLEAR;
                    else if (extd_addrd) cmd_d = C_EXTD;
                    else if (addr_loadd) cmd_d = C_LOAD;
                    else if (depd)       cmd_d = C_DEP;
                    else if (examd)      cmd_d = C_EXAM;
                    else if (contd)      cmd_d = C_CONT;
                    else                 cmd_d = C_NONE;
                end
            end
            S_DECODE: begin
                tmo_d = TMO_LOAD;
                fsm_d = S_DONE;
                case (cmd_q)
                    C_CLEAR: cpu_clear = 1'b1;
                    C_EXTD: begin
                        ifr_d = sr_q[5:3];
                        dfr_d = sr_q[2:0];
                    end
                    C_LOAD:  cpma_d = sr_q;
                    C_DEP:   fsm_d = S_MEM_WR;
                    C_EXAM:  fsm_d = S_MEM_RD;
                    C_CONT:  cpu_run = 1'b1;
                    default: fsm_d = S_DONE;
                endcase
            end
            S_MEM_RD, S_MEM_WR: begin
                // An ack on the terminal-count cycle still completes normally.
                if (mem_ack) begin
                    mb_d  = (fsm_q == S_MEM_WR) ? sr_q : mem_rdata;
                    fsm_d = S_INC;
                    tmo_d = '0;
                end else if (tmo_q == 4'd0) begin
                    mem_err_d = 1'b1;
                    fsm_d     = S_DONE;
                end else begin
                    tmo_d = tmo_q - 4'd1;
                end
            end
            S_INC: begin
                cpma_d = cpma_q + 12'd1;
                fsm_d  = S_DONE;
            end
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    assign mem_req   = (fsm_q == S_MEM_RD) || (fsm_q == S_MEM_WR);
    assign mem_we    = (fsm_q == S_MEM_WR);
    assign mem_addr  = {ifr_q, cpma_q};
    assign mem_wdata = sr_q;
    assign cpma      = cpma_q;
    assign ifr       = ifr_q;
    assign dfr       = dfr_q;
    assign mb        = mb_q;
    assign busy      = (fsm_q != S_IDLE);
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_panel_sequencer.sv
// Directed self-checking bench for panel_sequencer; expected values are hand-computed octal.
module tb_panel_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  state;
    logic        triggerd, cleard, extd_addrd, addr_loadd, depd, examd, contd;
    logic [11:0] sr, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata, cpma, mb;
    logic [2:0]  ifr, dfr;
    logic        cpu_clear, cpu_run, busy, mem_err;

    int errors = 0;
    int checks = 0;
    int cnt;

    panel_sequencer #(.HALT_STATE(5'h00), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .state(state), .triggerd(triggerd),
        .cleard(cleard), .extd_addrd(extd_addrd), .addr_loadd(addr_loadd),
        .depd(depd), .examd(examd), .contd(contd), .sr(sr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpma(cpma), .ifr(ifr), .dfr(dfr), .mb(mb), .cpu_clear(cpu_clear),
        .cpu_run(cpu_run), .busy(busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // bits = {clear, extd, load, dep, exam, cont}; strobes are dropped right after the
    // accept edge so the DUT must rely on its own latched command.
    task automatic press(input logic [5:0] bits);
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = bits;
        triggerd = 1'b1;
        tick();
        {cleard, extd_addrd, addr_loadd, depd, examd, contd} = '0;
    endtask

    task automatic unpress();
        triggerd = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b0; state = 5'h00; triggerd = 0; cleard = 0; extd_addrd = 0;
        addr_loadd = 0; depd = 0; examd = 0; contd = 0; sr = '0; mem_rdata = '0;
        mem_ack = 0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpma", cpma, 0);
        chk("rst_mb", mb, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 1'b1;
        tick();

        // LOAD ADD 0200
        sr = 12'o0200;
        press(6'b001000);
        chk("ld_busy_decode", busy, 1);
        chk("ld_cpma_early", cpma, 0);
        tick();
        chk("ld_req", mem_req, 0);
        tick();
        chk("ld_cpma", cpma, 12'o0200);
        chk("ld_busy_idle", busy, 0);
        unpress();

        // EXTD ADDR LOAD: ifr=2, dfr=5
        sr = 12'o0025;
        press(6'b010000);
        tick(); tick();
        chk("ex_ifr", ifr, 3'd2);
        chk("ex_dfr", dfr, 3'd5);
        chk("ex_cpma_keep", cpma, 12'o0200);
        unpress();

        // DEP 7402 at 2:0200, ack on third request cycle
        sr = 12'o7402;
        press(6'b000100);
        chk("dep_req_decode", mem_req, 0);
        sr = 12'o0000;
        tick();
        chk("dep_req", mem_req, 1);
        chk("dep_we", mem_we, 1);
        chk("dep_addr", mem_addr, 15'o20200);
        chk("dep_wdata", mem_wdata, 12'o7402);
        tick(); tick();
        chk("dep_req_c3", mem_req, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("dep_req_drop", mem_req, 0);
        chk("dep_mb", mb, 12'o7402);
        tick();
        chk("dep_cpma", cpma, 12'o0201);
        tick();
        chk("dep_busy_idle", busy, 0);
        unpress();

        // LOAD 7777 then EXAM with wrap
        sr = 12'o7777;
        press(6'b001000);
        tick(); tick();
        unpress();
        press(6'b000010);
        tick();
        chk("exam_req", mem_req, 1);
        chk("exam_we", mem_we, 0);
        chk("exam_addr", mem_addr, 15'o27777);
        mem_ack = 1'b1; mem_rdata = 12'o1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 12'o0;
        chk("exam_mb", mb, 12'o1234);
        tick();
        chk("exam_cpma_wrap", cpma, 12'o0000);
        chk("exam_ifr_keep", ifr, 3'd2);
        tick();
        unpress();

        // CLEAR beats DEP and EXAM
        press(6'b100110);
        chk("clr_pulse", cpu_clear, 1);
        chk("clr_req", mem_req, 0);
        tick();
        chk("clr_pulse_end", cpu_clear, 0);
        chk("clr_req2", mem_req, 0);
        tick();
        chk("clr_mb_keep", mb, 12'o1234);
        unpress();

        // CONT
        press(6'b000001);
        chk("cont_pulse", cpu_run, 1);
        tick();
        chk("cont_pulse_end", cpu_run, 0);
        tick();
        unpress();

        // LOAD ADD beats DEP
        sr = 12'o0055;
        press(6'b001100);
        tick();
        chk("pri_req", mem_req, 0);
        tick();
        chk("pri_cpma", cpma, 12'o0055);
        unpress();

        // EXAM with no ack: timeout
        press(6'b000010);
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            cnt++;
            tick();
        end
        chk("tmo_req_cycles", cnt, 15);
        chk("tmo_err", mem_err, 1);
        chk("tmo_mb_keep", mb, 12'o1234);
        mem_ack = 1'b1; mem_rdata = 12'o7777;
        tick();
        mem_ack = 1'b0; mem_rdata = 12'o0;
        tick();
        chk("late_ack_mb", mb, 12'o1234);
        chk("tmo_cpma_keep", cpma, 12'o0055);
        unpress();

        // LOAD ADD clears mem_err on accept
        sr = 12'o0100;
        press(6'b001000);
        chk("err_clear", mem_err, 0);
        tick(); tick();
        unpress();

        // EXAM with ack on the terminal cycle: normal completion
        press(6'b000010);
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("edge_req_c15", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 12'o4321;
        tick();
        mem_ack = 1'b0; mem_rdata = 12'o0;
        chk("edge_err", mem_err, 0);
        chk("edge_mb", mb, 12'o4321);
        tick();
        chk("edge_cpma", cpma, 12'o0101);
        tick();
        unpress();

        // Not halted: ignored
        state = 5'h01;
        sr = 12'o3333;
        press(6'b001000);
        chk("nohalt_busy", busy, 0);
        tick(); tick();
        chk("nohalt_cpma", cpma, 12'o0101);
        unpress();
        state = 5'h00;

        // Leaving halt mid-command does not abort
        sr = 12'o0777;
        press(6'b001000);
        state = 5'h1f;
        tick(); tick();
        chk("midrun_cpma", cpma, 12'o0777);
        state = 5'h00;
        unpress();

        // Async reset in the middle of a write
        sr = 12'o5555;
        press(6'b000100);
        tick();
        chk("ar_req_before", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_req", mem_req, 0);
        chk("ar_cpma", cpma, 0);
        chk("ar_ifr", ifr, 0);
        chk("ar_dfr", dfr, 0);
        chk("ar_mb", mb, 0);
        chk("ar_busy", busy, 0);
        triggerd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("ar_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
